// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage 16-bit pipeline.
// Optional stall statistics counter: define HAZARD_STALL_COUNT_EN.
module pipeline_hazard_controller #(
    parameter int MULDIV_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  id_op1,
    input  logic [3:0]  id_op2,
    input  logic        id_uses_op2,
    input  logic        id_halt,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_write_reg,
    input  logic        ex_muldiv_start,
    input  logic        ex_branch_taken,
    output logic        if_pc_stop,
    output logic        if_pc_mux,
    output logic        if_id_buffer_hold,
    output logic        if_id_buffer_flush,
    output logic        id_ex_buffer_hold,
    output logic        id_ex_buffer_flush,
    output logic        ex_mem_buffer_flush,
    output logic        muldiv_done,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MULDIV = 2'd1,
        HALT   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MULDIV_CYCLES - 2);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;

    assign load_use = ex_mem_read &&
        ((ex_write_reg == id_op1) ||
         (id_uses_op2 && (ex_write_reg == id_op2)));

    // State and mul/div counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and prioritised stall/flush outputs.
    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        if_pc_stop          = 1'b0;
        if_pc_mux           = 1'b0;
        if_id_buffer_hold   = 1'b0;
        if_id_buffer_flush  = 1'b0;
        id_ex_buffer_hold   = 1'b0;
        id_ex_buffer_flush  = 1'b0;
        ex_mem_buffer_flush = 1'b0;
        muldiv_done         = 1'b0;
        halted              = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_pc_mux          = 1'b1;
                        if_id_buffer_flush = 1'b1;
                        id_ex_buffer_flush = 1'b1;
                    end else if (ex_muldiv_start) begin
                        if_pc_stop          = 1'b1;
                        if_id_buffer_hold   = 1'b1;
                        id_ex_buffer_hold   = 1'b1;
                        ex_mem_buffer_flush = 1'b1;
                        state_d             = MULDIV;
                        cnt_d               = CNT_INIT;
                    end else if (load_use) begin
                        if_pc_stop         = 1'b1;
                        if_id_buffer_hold  = 1'b1;
                        id_ex_buffer_flush = 1'b1;
                    end else if (id_halt) begin
                        state_d = HALT;
                    end
                end
                MULDIV: begin
                    if (cnt_q != 4'd0) begin
                        if_pc_stop          = 1'b1;
                        if_id_buffer_hold   = 1'b1;
                        id_ex_buffer_hold   = 1'b1;
                        ex_mem_buffer_flush = 1'b1;
                        cnt_d               = cnt_q - 4'd1;
                    end else begin
                        muldiv_done = 1'b1;
                        state_d     = RUN;
                    end
                end
                HALT: begin
                    if_pc_stop         = 1'b1;
                    if_id_buffer_hold  = 1'b1;
                    id_ex_buffer_flush = 1'b1;
                    halted             = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of PC-frozen cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else if (if_pc_stop && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_count = reset ? 16'h0000 : stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage 16-bit pipeline; fills the HAZARD UNIT / BRANCH CONTROL role in cpu.
- Drives the PC stop and PC-mux selects and the hold/flush controls of the IF/ID, ID/EX and EX/MEM buffers.
- Handles load-use stalls, taken branch/jump flushes, multi-cycle mul/div occupancy of EX, and the halt instruction.

Parameters:
- MULDIV_CYCLES, 8, number of cycles a mul/div instruction occupies EX; legal range 2..16.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_op1  in  4  source register 1 of the instruction in ID.
- id_op2  in  4  source register 2 of the instruction in ID.
- id_uses_op2  in  1  the ID instruction reads id_op2.
- id_halt  in  1  the ID instruction is HALT.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_write_reg  in  4  destination register of the EX instruction.
- ex_muldiv_start  in  1  the EX instruction is mul/div.
- ex_branch_taken  in  1  a branch/jump resolved taken in EX.
- if_pc_stop  out  1  freeze the PC.
- if_pc_mux  out  1  select the branch target into the PC.
- if_id_buffer_hold  out  1  hold IF/ID.
- if_id_buffer_flush  out  1  clear IF/ID.
- id_ex_buffer_hold  out  1  hold ID/EX.
- id_ex_buffer_flush  out  1  clear ID/EX (bubble).
- ex_mem_buffer_flush  out  1  insert a bubble into EX/MEM.
- muldiv_done  out  1  one-cycle pulse on the final mul/div cycle.
- halted  out  1  controller is in HALT.
- stall_count  out  16  stall statistics (see Optional Feature).

Behaviour:
- Interface: one clock, `clock`; reset is `reset`, synchronous and active-high.
- State machine: RUN, MULDIV, HALT. Internal 4-bit down-counter `cnt`.
- Outputs are combinational from the current state and inputs. While `reset` is high, every output is 0. On the reset edge: state goes to RUN, `cnt` goes to 0, and `stall_count` goes to 0.
- Priority in RUN (highest first): branch, mul/div, load-use, halt. Exactly one action is taken per cycle.
- Branch (RUN, ex_branch_taken=1):
  - if_pc_mux=1, if_id_buffer_flush=1, id_ex_buffer_flush=1 for that cycle only. Stay in RUN.
  - A coincident load-use or id_halt is discarded, because that instruction is flushed.
  - If ex_muldiv_start=1 in the same cycle, the branch wins and MULDIV is not entered.
- Mul/div entry (RUN, ex_muldiv_start=1):
  - if_pc_stop=1, if_id_buffer_hold=1, id_ex_buffer_hold=1, ex_mem_buffer_flush=1.
  - Next state MULDIV; cnt := MULDIV_CYCLES-2.
- MULDIV state:
  - ex_muldiv_start is ignored. ex_branch_taken is ignored (the EX instruction is the mul/div).
  - cnt != 0: the same four stall outputs are asserted; cnt decrements.
  - cnt == 0: muldiv_done=1, all stalls deassert, next state RUN.
  - Net effect: MULDIV_CYCLES-1 stall cycles; EX/MEM captures the result on the done cycle.
- Load-use (RUN, ex_mem_read=1, and either ex_write_reg==id_op1 or (id_uses_op2=1 and ex_write_reg==id_op2)):
  - if_pc_stop=1, if_id_buffer_hold=1, id_ex_buffer_flush=1 for exactly one cycle.
  - No state change. The bubble clears the hazard on the next cycle.
- Halt (RUN, id_halt=1, no higher-priority event): next state HALT. The halt cycle itself produces no stall.
- HALT state:
  - if_pc_stop=1, if_id_buffer_hold=1, id_ex_buffer_flush=1, halted=1.
  - Older instructions drain through EX/MEM/WB.
  - Only reset exits HALT; all other inputs are ignored.
- Reset mid-MULDIV: the operation is aborted, muldiv_done never pulses, and the controller is in RUN the next cycle.
- Non-event cycles in RUN: all outputs are 0.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- Defined: stall_count increments by 1 on every non-reset cycle with if_pc_stop=1, including HALT cycles. It saturates at 16'hFFFF and clears on reset.
- Undefined: stall_count is tied to 16'h0000 and no counter logic exists. The port is always present.

Test Plan:
- Load-use: ex_mem_read=1, ex_write_reg=4'h3, id_op1=4'h3 -> one cycle of if_pc_stop=1, if_id_buffer_hold=1, id_ex_buffer_flush=1; with id_op2=4'h3 and id_uses_op2=0, no stall.
- Branch beats load-use: ex_branch_taken=1 plus a matching load-use -> if_pc_mux=1 and both flushes=1 in that cycle only; if_pc_stop=0; state stays RUN.
- Mul/div with MULDIV_CYCLES=8: ex_muldiv_start held at 1 -> stalls for 7 cycles, muldiv_done=1 on the 8th cycle with stalls 0, no retrigger; with the macro defined, stall_count=16'h0007.
- Reset mid-mul/div: assert reset in the 3rd MULDIV cycle -> outputs 0 during reset, muldiv_done never pulses, RUN afterwards, stall_count=0.
- Halt: id_halt=1 -> next cycle halted=1, if_pc_stop=1, id_ex_buffer_flush=1, persisting 20+ cycles despite ex_branch_taken and ex_muldiv_start pulses; reset returns to RUN.
- Halt vs branch: id_halt=1 with ex_branch_taken=1 -> flush performed, halted stays 0.
